// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier controller.
// Contents:
//   STATE_W   - width of the controller state encoding
//   CNT_W_DEF - default iteration counter width
//   state_e   - controller state enumeration
package mul_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StLoadB = 3'd2,
    StCheck = 3'd3,
    StAccum = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for a repeated-addition multiplier datapath (A, B, P
// registers, adder, B decrementer, B zero detector). Loads operands, clears P,
// then loops accumulate/decrement until B reaches zero. Completion and
// iteration-limit errors are held until acknowledged; abort returns to idle.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - begin a multiply (only looked at while idle)
//   abort    - cancel the operation in progress (any non-idle state)
//   done_ack - host acknowledge, releases done/err
//   eqz      - datapath B register is zero
//   ld_a     - load A from operand bus
//   ld_b     - load B from operand bus
//   clr_p    - clear P
//   ld_p     - load P with P + A
//   dec_b    - decrement B
//   busy     - controller not idle
//   done     - product valid in P (held)
//   err      - iteration limit reached (held)
//   iter_cnt - accumulate steps performed in the current/last run
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned MAX_ITER = 32'h0000_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             done_ack,
  input  logic             eqz,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_p,
  output logic             ld_p,
  output logic             dec_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [CNT_W-1:0] MaxIter = CNT_W'(MAX_ITER);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoadA;
      end
      StLoadA: state_d = StLoadB;
      StLoadB: begin
        cnt_d   = '0;
        state_d = StCheck;
      end
      StCheck: begin
        // eqz reflects the B load/decrement of the previous cycle.
        if (eqz)                  state_d = StDone;
        else if (cnt_q == MaxIter) state_d = StErr;
        else                      state_d = StAccum;
      end
      StAccum: begin
        // CHECK guarantees cnt_q < MaxIter here; the guard keeps it from wrapping.
        if (cnt_q != MaxIter) cnt_d = cnt_q + CNT_W'(1);
        state_d = StCheck;
      end
      StDone: begin
        if (done_ack) state_d = StIdle;
      end
      StErr: begin
        if (done_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort beats everything outside idle; the count is frozen where it was.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = cnt_q;
    end
  end

  // Moore outputs, decoded from the state register only.
  always_comb begin
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    clr_p = 1'b0;
    ld_p  = 1'b0;
    dec_b = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    busy  = (state_q != StIdle);
    unique case (state_q)
      StIdle:  ;
      StLoadA: ld_a = 1'b1;
      StLoadB: begin
        ld_b  = 1'b1;
        clr_p = 1'b1;
      end
      StCheck: ;
      StAccum: begin
        ld_p  = 1'b1;
        dec_b = 1'b1;
      end
      StDone:  done = 1'b1;
      StErr:   err  = 1'b1;
      default: ;
    endcase
  end

  assign iter_cnt = cnt_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= MaxIter);
  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done && err));
  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n) state_q <= StErr);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: three controllers (iteration limits 0xFFFF, 4, 0),
// each with a behavioural A/B/P datapath. Table vectors, directed corner
// sequences and random operands checked against closed-form expectations.
module tb_mul_seq_ctrl;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_s [NDUT];
  logic        abort_s [NDUT];
  logic        ack_s   [NDUT];
  logic [7:0]  opa_s   [NDUT];
  logic [7:0]  opb_s   [NDUT];
  logic        ld_a_s  [NDUT];
  logic        ld_b_s  [NDUT];
  logic        clr_p_s [NDUT];
  logic        ld_p_s  [NDUT];
  logic        dec_b_s [NDUT];
  logic        busy_s  [NDUT];
  logic        done_s  [NDUT];
  logic        err_s   [NDUT];
  logic [15:0] iter_s  [NDUT];
  logic [31:0] p_s     [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned Mx = (g == 0) ? 32'hFFFF : ((g == 1) ? 4 : 0);
    logic [7:0]  a_r, b_r;
    logic [31:0] p_r;
    logic        eqz;

    assign eqz    = (b_r == 8'd0);
    assign p_s[g] = p_r;

    mul_seq_ctrl #(.CNT_W(16), .MAX_ITER(Mx)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_s[g]),
      .abort    (abort_s[g]),
      .done_ack (ack_s[g]),
      .eqz      (eqz),
      .ld_a     (ld_a_s[g]),
      .ld_b     (ld_b_s[g]),
      .clr_p    (clr_p_s[g]),
      .ld_p     (ld_p_s[g]),
      .dec_b    (dec_b_s[g]),
      .busy     (busy_s[g]),
      .done     (done_s[g]),
      .err      (err_s[g]),
      .iter_cnt (iter_s[g])
    );

    // Behavioural datapath.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_r <= '0;
        b_r <= '0;
        p_r <= '0;
      end else begin
        if (ld_a_s[g])  a_r <= opa_s[g];
        if (ld_b_s[g])  b_r <= opb_s[g];
        if (dec_b_s[g]) b_r <= b_r - 8'd1;
        if (clr_p_s[g]) p_r <= '0;
        if (ld_p_s[g])  p_r <= p_r + 32'(a_r);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  function automatic int max_of(input int i);
    return (i == 0) ? 32'hFFFF : ((i == 1) ? 4 : 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_mask(input int n);
    logic [127:0] m;
    m = '0;
    for (int j = 1; j <= n; j++) m[2 + 2 * j] = 1'b1;
    return m;
  endfunction

  function automatic logic [8:0] outs(input int i);
    return {ld_a_s[i], ld_b_s[i], clr_p_s[i], ld_p_s[i], dec_b_s[i], busy_s[i], done_s[i],
            err_s[i], 1'b0};
  endfunction

  // Starts an operation and follows it to done/err. kind: 0 timeout, 1 done, 2 err.
  task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b, input bit noise,
                        output int kind, output int cyc, output logic [127:0] mask,
                        output int bb);
    opa_s[i] = a;
    opb_s[i] = b;
    mask = '0;
    bb = 0;
    kind = 0;
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
    cyc = 1;
    while (cyc < 120) begin
      if (ld_p_s[i]) mask[cyc] = 1'b1;
      if (!busy_s[i]) bb++;
      if (done_s[i]) begin kind = 1; break; end
      if (err_s[i]) begin kind = 2; break; end
      if (noise) begin
        start_s[i] = 1'($urandom % 2);
        ack_s[i]   = 1'($urandom % 2);
      end
      tick();
      cyc++;
    end
    start_s[i] = 1'b0;
    ack_s[i]   = 1'b0;
  endtask

  // Full run with checks against the closed-form expectation.
  task automatic do_run(input string nm, input int i, input logic [7:0] a, input logic [7:0] b,
                        input bit noise);
    int kind, cyc, bb, mx, n, ekind;
    logic [127:0] mask;
    mx = max_of(i);
    n = (int'(b) <= mx) ? int'(b) : mx;
    ekind = (int'(b) <= mx) ? 1 : 2;
    run_op(i, a, b, noise, kind, cyc, mask, bb);
    chk({nm, " kind"}, 128'(kind), 128'(ekind));
    chk({nm, " cycle"}, 128'(cyc), 128'(4 + 2 * n));
    chk({nm, " flags"}, {done_s[i], err_s[i]}, (ekind == 1) ? 2'b10 : 2'b01);
    chk({nm, " P"}, p_s[i], 32'(int'(a) * n));
    chk({nm, " iter_cnt"}, iter_s[i], 16'(n));
    chk({nm, " ld_p cycles"}, mask, exp_mask(n));
    chk({nm, " busy gaps"}, 128'(bb), 128'(0));
  endtask

  task automatic ack_op(input string nm, input int i);
    ack_s[i] = 1'b1;
    tick();
    ack_s[i] = 1'b0;
    chk({nm, " idle after ack"}, outs(i), 9'd0);
  endtask

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int kind, cyc, bb, bad;
    logic [127:0] mask;

    tbl[0] = '{idx: 0, a: 8'd5,  b: 8'd3};   // done at 10, P=15
    tbl[1] = '{idx: 0, a: 8'd9,  b: 8'd0};   // done at 4, P=0
    tbl[2] = '{idx: 1, a: 8'd3,  b: 8'd7};   // limit 4: err at 12
    tbl[3] = '{idx: 1, a: 8'd2,  b: 8'd4};   // limit 4: exactly reaches zero, done at 12
    tbl[4] = '{idx: 2, a: 8'd6,  b: 8'd0};   // limit 0: done at 4
    tbl[5] = '{idx: 2, a: 8'd6,  b: 8'd2};   // limit 0: err at 4

    for (int i = 0; i < NDUT; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      ack_s[i]   = 1'b0;
      opa_s[i]   = '0;
      opb_s[i]   = '0;
    end

    // Reset state.
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset outs dut%0d", i), outs(i), 9'd0);
      chk($sformatf("reset iter dut%0d", i), iter_s[i], 16'd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle after reset release", outs(0), 9'd0);

    // Table vectors.
    for (int k = 0; k < 6; k++) begin
      do_run($sformatf("tbl%0d", k), tbl[k].idx, tbl[k].a, tbl[k].b, 1'b0);
      ack_op($sformatf("tbl%0d", k), tbl[k].idx);
    end

    // Done held without ack while start toggles; ack+start together returns idle.
    do_run("held", 0, 8'd5, 8'd3, 1'b0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      start_s[0] = 1'(k % 2);
      tick();
      if (!done_s[0] || ld_a_s[0] || !busy_s[0]) bad++;
    end
    chk("held done 20 cycles", 128'(bad), 128'(0));
    start_s[0] = 1'b1;
    ack_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    ack_s[0] = 1'b0;
    chk("held ack+start -> idle", outs(0), 9'd0);
    tick();
    chk("held stays idle", outs(0), 9'd0);
    do_run("held fresh", 0, 8'd7, 8'd2, 1'b0);
    ack_op("held fresh", 0);

    // Abort in cycle 7 (a CHECK) of a B=10 run.
    opa_s[0] = 8'd3;
    opb_s[0] = 8'd10;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int k = 1; k < 7; k++) tick();
    abort_s[0] = 1'b1;
    ack_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    ack_s[0] = 1'b0;
    chk("abort -> idle", outs(0), 9'd0);
    chk("abort iter_cnt kept", iter_s[0], 16'd2);
    tick(); tick();
    chk("abort stays idle", outs(0), 9'd0);
    do_run("after abort", 0, 8'd11, 8'd4, 1'b0);
    ack_op("after abort", 0);

    // Asynchronous reset mid-ACCUM.
    opa_s[0] = 8'd4;
    opb_s[0] = 8'd2;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    tick(); tick(); tick();
    chk("pre-reset in ACCUM", {ld_p_s[0], dec_b_s[0], busy_s[0]}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outs", outs(0), 9'd0);
    chk("async reset iter", iter_s[0], 16'd0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (outs(0) != 9'd0) bad++;
    end
    chk("idle after async reset", 128'(bad), 128'(0));
    do_run("after reset", 0, 8'd4, 8'd2, 1'b0);
    ack_op("after reset", 0);

    // Random operands with start/ack noise during the run.
    for (int r = 0; r < 40; r++) begin
      int i;
      logic [7:0] a, b;
      i = int'($urandom % NDUT);
      a = 8'($urandom % 256);
      b = 8'($urandom % 13);
      do_run($sformatf("rnd%0d dut%0d a=%0d b=%0d", r, i, a, b), i, a, b, 1'b1);
      for (int k = int'($urandom % 3); k > 0; k--) tick();
      ack_op($sformatf("rnd%0d", r), i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
